// File: rtl/spill_reg_pkg.sv
// spill_reg_pkg: shared types for the two-entry spill register.
// Holds the occupancy encoding and the flop-state struct so checkers can
// bind to a single named view of the stage's internal state.
package spill_reg_pkg;

  // Number of beats the stage can hold.
  localparam int unsigned SPILL_DEPTH = 2;

  // Occupancy of the stage, decoded from the two full flags.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Full flags of the two storage registers. B always holds the older beat.
  typedef struct packed {
    logic a_full;
    logic b_full;
  } fill_state_t;

  // Decode the two full flags into an occupancy count.
  function automatic occ_e occ_of(input fill_state_t st);
    occ_e occ;
    case ({st.a_full, st.b_full})
      2'b00:   occ = OCC_EMPTY;
      2'b11:   occ = OCC_TWO;
      default: occ = OCC_ONE;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/spill_reg.sv
// spill_reg: two-entry elastic stage that cuts every combinational path
// between an upstream and a downstream valid/ready channel. All outputs are
// driven from flops; one beat per cycle, one cycle of forward latency.
//
// Optional macro SPILL_REG_ASSERT_EN compiles in simulation-only protocol
// checks. The synthesizable logic is the same with or without it.
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high. A producer that raises valid keeps it high with stable data until the
// transfer; ready may be raised or dropped freely and never depends on valid
// within the same cycle.
module spill_reg
  import spill_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);

  fill_state_t      st;
  logic [WIDTH-1:0] a_data;
  logic [WIDTH-1:0] b_data;
  occ_e             occ;

  logic a_fill;
  logic a_drain;
  logic b_fill;
  logic b_drain;

  // Occupancy view of the full flags; outputs derive from it so they are
  // functions of flops only.
  assign occ = occ_of(st);

  // A accepts when the stage has room; A moves into B only when B is empty,
  // and that move is kept (b_fill) only if downstream did not take it.
  always_comb begin
    a_fill  = valid_i & ready_o;
    a_drain = st.a_full & ~st.b_full;
    b_fill  = a_drain & ~ready_i;
    b_drain = st.b_full & ready_i;
  end

  // Full flags: reset clears both, otherwise fill/drain bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st.a_full <= 1'b0;
      st.b_full <= 1'b0;
    end else begin
      st.a_full <= a_fill | (st.a_full & ~a_drain);
      st.b_full <= b_fill | (st.b_full & ~b_drain);
    end
  end

  // Payload registers: A captures upstream data, B captures A on a spill.
  // Data is opaque and moved bit-for-bit, so X bits pass through unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_data <= '0;
      b_data <= '0;
    end else begin
      if (a_fill) a_data <= data_i;
      if (b_fill) b_data <= a_data;
    end
  end

  // Outputs: B is the older beat, so it is presented first when occupied.
  always_comb begin
    ready_o = (occ != OCC_TWO);
    valid_o = (occ != OCC_EMPTY);
    data_o  = st.b_full ? b_data : a_data;
  end

`ifdef SPILL_REG_ASSERT_EN
  // A zero-width payload is meaningless.
  if (WIDTH < 1) begin : g_width_check
    $error("spill_reg: WIDTH must be at least 1");
  end

  // Downstream must see a stable beat while it stalls.
  property p_out_stable;
    @(posedge clk_i) disable iff (rst_i)
      (valid_o & ~ready_i) |=> (valid_o & (data_o === $past(data_o)));
  endproperty
  a_out_stable: assert property (p_out_stable)
    else $error("spill_reg: valid_o/data_o changed during downstream stall");

  // Both registers full must always close the upstream channel.
  a_full_ready: assert property (@(posedge clk_i) disable iff (rst_i)
      !(st.a_full & st.b_full & ready_o))
    else $error("spill_reg: ready_o high while both entries are full");

  // Upstream withdrawing a beat it has not yet handed over.
  property p_in_stable;
    @(posedge clk_i) disable iff (rst_i)
      (valid_i & ~ready_o) |=> valid_i;
  endproperty
  a_in_stable: assert property (p_in_stable)
    else $warning("spill_reg: upstream dropped valid_i while ready_o was low");
`endif

endmodule

// File: tb/tb_spill_reg.sv
// tb_spill_reg: self-checking bench for spill_reg with directed scenarios
// and a random valid/ready run, backed by an in-order scoreboard.
module tb_spill_reg;

  localparam int unsigned W = 32;

  logic         clk_i;
  logic         rst_i;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] data_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] data_o;

  int checks;
  int failures;
  int pops;

  logic [W-1:0] exp_q[$];

  logic         prev_stall;
  logic [W-1:0] prev_data;

  spill_reg #(.WIDTH(W)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // ---------------- scoreboard monitor ----------------
  // Sampled on the falling edge: inputs were driven just after the rising
  // edge, so what is seen here is what the next rising edge will act on.
  initial begin
    prev_stall = 1'b0;
    prev_data  = '0;
    pops       = 0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (valid_o !== 1'b1 || data_o !== prev_data) begin
            failures++;
            $display("FAIL stall_hold: valid_o=%b data_o=%h required valid_o=1 data_o=%h",
                     valid_o, data_o, prev_data);
          end
        end
        if (valid_o === 1'b1 && ready_i === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_extra: data_o=%h delivered with nothing expected", data_o);
          end else begin
            logic [W-1:0] exp;
            exp = exp_q.pop_front();
            pops++;
            if (data_o !== exp) begin
              failures++;
              $display("FAIL sb_data: data_o=%h required %h", data_o, exp);
            end
          end
        end
        if (valid_i === 1'b1 && ready_o === 1'b1) exp_q.push_back(data_i);
        prev_stall = (valid_o === 1'b1) && (ready_i === 1'b0);
        prev_data  = data_o;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i   = 1'b1;
    valid_i = 1'b1;
    data_i  = 32'hDEAD_BEEF;
    ready_i = 1'b0;
    cyc();
    cyc();
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || data_o !== '0) begin
      failures++;
      $display("FAIL reset_out: valid_o=%b ready_o=%b data_o=%h required 0 1 0",
               valid_o, ready_o, data_o);
    end
    rst_i   = 1'b0;
    valid_i = 1'b0;
    cyc();
    checks++;
    if (valid_o !== 1'b0 || data_o !== '0) begin
      failures++;
      $display("FAIL reset_capture: valid_o=%b data_o=%h required 0 0", valid_o, data_o);
    end
  endtask

  task automatic test_streaming();
    ready_i = 1'b1;
    valid_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      data_i = W'(i);
      cyc();
      checks++;
      if (valid_o !== 1'b1 || data_o !== W'(i) || ready_o !== 1'b1) begin
        failures++;
        $display("FAIL stream_%0d: valid_o=%b data_o=%h ready_o=%b required 1 %h 1",
                 i, valid_o, data_o, ready_o, W'(i));
      end
    end
    valid_i = 1'b0;
    cyc();
    checks++;
    if (valid_o !== 1'b0) begin
      failures++;
      $display("FAIL stream_empty: valid_o=%b required 0", valid_o);
    end
  endtask

  task automatic test_backpressure();
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i  = 32'hA;
    cyc();
    checks++;
    if (valid_o !== 1'b1 || data_o !== 32'hA || ready_o !== 1'b1) begin
      failures++;
      $display("FAIL bp_first: valid_o=%b data_o=%h ready_o=%b required 1 a 1",
               valid_o, data_o, ready_o);
    end
    data_i = 32'hB;
    cyc();
    checks++;
    if (ready_o !== 1'b0 || data_o !== 32'hA) begin
      failures++;
      $display("FAIL bp_full: ready_o=%b data_o=%h required 0 a", ready_o, data_o);
    end
    data_i = 32'hC;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++;
      if (ready_o !== 1'b0 || valid_o !== 1'b1 || data_o !== 32'hA) begin
        failures++;
        $display("FAIL bp_hold_%0d: ready_o=%b valid_o=%b data_o=%h required 0 1 a",
                 i, ready_o, valid_o, data_o);
      end
    end
  endtask

  task automatic test_drain_order();
    ready_i = 1'b1;
    cyc();
    checks++;
    if (data_o !== 32'hB || valid_o !== 1'b1 || ready_o !== 1'b1) begin
      failures++;
      $display("FAIL drain_b: data_o=%h valid_o=%b ready_o=%b required b 1 1",
               data_o, valid_o, ready_o);
    end
    cyc();
    checks++;
    if (data_o !== 32'hC || valid_o !== 1'b1) begin
      failures++;
      $display("FAIL drain_c: data_o=%h valid_o=%b required c 1", data_o, valid_o);
    end
    valid_i = 1'b0;
    cyc();
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      failures++;
      $display("FAIL drain_empty: valid_o=%b ready_o=%b required 0 1", valid_o, ready_o);
    end
  endtask

  task automatic test_mid_reset();
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i  = 32'h11;
    cyc();
    data_i  = 32'h22;
    cyc();
    checks++;
    if (ready_o !== 1'b0) begin
      failures++;
      $display("FAIL mrst_full: ready_o=%b required 0", ready_o);
    end
    rst_i   = 1'b1;
    valid_i = 1'b0;
    cyc();
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || data_o !== '0) begin
      failures++;
      $display("FAIL mrst_out: valid_o=%b ready_o=%b data_o=%h required 0 1 0",
               valid_o, ready_o, data_o);
    end
    rst_i   = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (valid_o !== 1'b0) begin
        failures++;
        $display("FAIL mrst_leak_%0d: valid_o=%b data_o=%h required valid_o=0",
                 i, valid_o, data_o);
      end
    end
  endtask

  task automatic test_random();
    int start_pops;
    int drained;
    start_pops = pops;
    valid_i = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      // A pending beat stays put with its data until it is accepted.
      if (!(valid_i && !ready_o)) begin
        valid_i = ($urandom_range(0, 3) != 0);
        data_i  = $urandom();
      end
      ready_i = ($urandom_range(0, 2) != 0);
      cyc();
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    drained = 0;
    while (valid_o === 1'b1 && drained < 10) begin
      cyc();
      drained++;
    end
    @(negedge clk_i);
    checks++;
    if (exp_q.size() != 0 || valid_o !== 1'b0) begin
      failures++;
      $display("FAIL rand_drain: left=%0d valid_o=%b required 0 0", exp_q.size(), valid_o);
    end
    checks++;
    if (pops - start_pops < 2000) begin
      failures++;
      $display("FAIL rand_traffic: delivered=%0d required at least 2000", pops - start_pops);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    rst_i    = 1'b1;
    valid_i  = 1'b0;
    ready_i  = 1'b0;
    data_i   = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_drain_order();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
